vlsu_shf_cmt_sequencer: RTL and testbench

Control sequencer for the VLSU load shuffle datapath. It queues per-request shuffle meta info and gates each sequential-buffer beat into the shuffle registers. It also generates the per-beat VRF set address and tracks the per-lane drain of the shuffle buffer. It reports request completion once the final beat of a request has been accepted by every lane.

---
 rtl/vlsu_shf_cmt_sequencer.sv | 149 ++++++++++++++
 tb/tb_vlsu_shf_cmt_sequencer.sv | 292 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/vlsu_shf_cmt_sequencer.sv
// Load-shuffle commit sequencer: queues per-request meta info, gates sequential-buffer
// beats into the shuffle registers, steps the VRF set address and tracks per-lane drain.
module vlsu_shf_cmt_sequencer #(
  parameter int unsigned NrLanes   = 4,
  parameter int unsigned InfoDepth = 4,
  parameter int unsigned ReqIdW    = 4,
  parameter int unsigned CntW      = 8,
  parameter int unsigned SetW      = 10,
  parameter int unsigned OffW      = 3
) (
  input  logic               clk_i,
  input  logic               rst_i,
  input  logic               meta_valid_i,
  output logic               meta_ready_o,
  input  logic [ReqIdW-1:0]  meta_req_id_i,
  input  logic               meta_vm_i,
  input  logic [CntW-1:0]    meta_cnt_i,
  input  logic [SetW-1:0]    meta_set_i,
  input  logic [OffW-1:0]    meta_off_i,
  input  logic               seq_valid_i,
  output logic               seq_ready_o,
  input  logic               mask_valid_i,
  output logic               mask_ready_o,
  output logic               cmt_o,
  output logic [ReqIdW-1:0]  cur_req_id_o,
  output logic               cur_vm_o,
  output logic [SetW-1:0]    cur_set_o,
  output logic [OffW-1:0]    cur_off_o,
  output logic [NrLanes-1:0] lane_valid_o,
  input  logic [NrLanes-1:0] lane_ready_i,
  output logic               done_valid_o,
  output logic [ReqIdW-1:0]  done_req_id_o,
  output logic               busy_o
);

  localparam int unsigned PtrW = (InfoDepth > 1) ? $clog2(InfoDepth) : 1;

  typedef struct packed {
    logic [ReqIdW-1:0] req_id;
    logic              vm;
    logic [CntW-1:0]   cnt;
    logic [SetW-1:0]   set;
    logic [OffW-1:0]   off;
  } meta_t;

  meta_t             mem_q [InfoDepth];
  logic [PtrW-1:0]   enq_ptr_q, enq_ptr_d, deq_ptr_q, deq_ptr_d;
  logic              enq_wrap_q, enq_wrap_d, deq_wrap_q, deq_wrap_d;
  logic [NrLanes-1:0] pend_q, pend_d, pend_acked;
  logic [CntW-1:0]   beat_idx_q, beat_idx_d;
  logic              last_pend_q, last_pend_d;
  logic [ReqIdW-1:0] pend_id_q, pend_id_d;
  logic              done_valid_q, done_valid_d;
  logic [ReqIdW-1:0] done_req_id_q, done_req_id_d;

  logic  empty, full, enq, deq, cmt, last_beat;
  meta_t head, meta_in;

  assign empty = (enq_ptr_q == deq_ptr_q) && (enq_wrap_q == deq_wrap_q);
  assign full  = (enq_ptr_q == deq_ptr_q) && (enq_wrap_q != deq_wrap_q);
  assign head  = mem_q[deq_ptr_q];

  assign meta_in = '{req_id: meta_req_id_i, vm: meta_vm_i, cnt: meta_cnt_i,
                     set: meta_set_i, off: meta_off_i};

  assign meta_ready_o = !full;
  assign enq          = meta_valid_i && !full;

  // Pend is not bypassed: a beat waits until every lane has taken the previous one.
  assign seq_ready_o  = (pend_q == '0) && !empty && (head.vm || mask_valid_i);
  assign cmt          = seq_valid_i && seq_ready_o;
  assign cmt_o        = cmt;
  assign mask_ready_o = cmt && !head.vm;
  assign last_beat    = (beat_idx_q == head.cnt);
  assign deq          = cmt && last_beat;

  assign cur_req_id_o = head.req_id;
  assign cur_vm_o     = head.vm;
  assign cur_set_o    = head.set + SetW'(beat_idx_q);
  assign cur_off_o    = head.off;

  assign lane_valid_o  = pend_q;
  assign done_valid_o  = done_valid_q;
  assign done_req_id_o = done_req_id_q;
  assign busy_o        = !empty || (pend_q != '0) || done_valid_q;

  always_comb begin
    {enq_wrap_d, enq_ptr_d} = {enq_wrap_q, enq_ptr_q};
    {deq_wrap_d, deq_ptr_d} = {deq_wrap_q, deq_ptr_q};
    if (enq) {enq_wrap_d, enq_ptr_d} = {enq_wrap_q, enq_ptr_q} + (PtrW+1)'(1);
    if (deq) {deq_wrap_d, deq_ptr_d} = {deq_wrap_q, deq_ptr_q} + (PtrW+1)'(1);
  end

  always_comb begin
    pend_acked    = pend_q & ~lane_ready_i;
    pend_d        = pend_acked;
    beat_idx_d    = beat_idx_q;
    last_pend_d   = last_pend_q;
    pend_id_d     = pend_id_q;
    // Done fires only on the cycle the final beat's last lane ack empties pend.
    done_valid_d  = (pend_q != '0) && (pend_acked == '0) && last_pend_q;
    done_req_id_d = done_req_id_q;
    if (done_valid_d) begin
      done_req_id_d = pend_id_q;
      last_pend_d   = 1'b0;
    end
    if (cmt) begin
      pend_d      = '1;
      last_pend_d = last_beat;
      pend_id_d   = head.req_id;
      beat_idx_d  = last_beat ? '0 : beat_idx_q + CntW'(1);
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      for (int i = 0; i < int'(InfoDepth); i++) mem_q[i] <= '0;
      enq_ptr_q     <= '0;
      enq_wrap_q    <= 1'b0;
      deq_ptr_q     <= '0;
      deq_wrap_q    <= 1'b0;
      pend_q        <= '0;
      beat_idx_q    <= '0;
      last_pend_q   <= 1'b0;
      pend_id_q     <= '0;
      done_valid_q  <= 1'b0;
      done_req_id_q <= '0;
    end else begin
      if (enq) mem_q[enq_ptr_q] <= meta_in;
      enq_ptr_q     <= enq_ptr_d;
      enq_wrap_q    <= enq_wrap_d;
      deq_ptr_q     <= deq_ptr_d;
      deq_wrap_q    <= deq_wrap_d;
      pend_q        <= pend_d;
      beat_idx_q    <= beat_idx_d;
      last_pend_q   <= last_pend_d;
      pend_id_q     <= pend_id_d;
      done_valid_q  <= done_valid_d;
      done_req_id_q <= done_req_id_d;
    end
  end

`ifndef SYNTHESIS
  seq_valid_needs_entry: assert property (@(posedge clk_i) disable iff (rst_i)
    seq_valid_i |-> !empty)
    else $error("seq_valid_i asserted while meta queue is empty");
`endif

endmodule

// File: tb/tb_vlsu_shf_cmt_sequencer.sv
// Randomized and directed checks of vlsu_shf_cmt_sequencer against a queue-level model.
module tb_vlsu_shf_cmt_sequencer;
  localparam int NrLanes = 4, InfoDepth = 4, ReqIdW = 4, CntW = 8, SetW = 10, OffW = 3;

  logic clk_i = 1'b0;
  logic rst_i = 1'b1;
  logic meta_valid_i, meta_ready_o, meta_vm_i;
  logic [ReqIdW-1:0] meta_req_id_i, cur_req_id_o, done_req_id_o;
  logic [CntW-1:0] meta_cnt_i;
  logic [SetW-1:0] meta_set_i, cur_set_o;
  logic [OffW-1:0] meta_off_i, cur_off_o;
  logic seq_valid_i, seq_ready_o, mask_valid_i, mask_ready_o, cmt_o, cur_vm_o;
  logic [NrLanes-1:0] lane_valid_o, lane_ready_i;
  logic done_valid_o, busy_o;

  always #5 clk_i = ~clk_i;

  vlsu_shf_cmt_sequencer #(
    .NrLanes(NrLanes), .InfoDepth(InfoDepth), .ReqIdW(ReqIdW),
    .CntW(CntW), .SetW(SetW), .OffW(OffW)
  ) dut (
    .clk_i(clk_i), .rst_i(rst_i),
    .meta_valid_i(meta_valid_i), .meta_ready_o(meta_ready_o),
    .meta_req_id_i(meta_req_id_i), .meta_vm_i(meta_vm_i), .meta_cnt_i(meta_cnt_i),
    .meta_set_i(meta_set_i), .meta_off_i(meta_off_i),
    .seq_valid_i(seq_valid_i), .seq_ready_o(seq_ready_o),
    .mask_valid_i(mask_valid_i), .mask_ready_o(mask_ready_o), .cmt_o(cmt_o),
    .cur_req_id_o(cur_req_id_o), .cur_vm_o(cur_vm_o), .cur_set_o(cur_set_o),
    .cur_off_o(cur_off_o), .lane_valid_o(lane_valid_o), .lane_ready_i(lane_ready_i),
    .done_valid_o(done_valid_o), .done_req_id_o(done_req_id_o), .busy_o(busy_o)
  );

  typedef struct {
    int id;
    bit vm;
    int cnt;
    int set;
    int off;
  } req_t;

  // Reference model: a list of outstanding requests plus the in-flight beat.
  req_t mq[$];
  int   m_beat;
  logic [NrLanes-1:0] m_pend;
  bit   m_last;
  int   m_pend_id;
  bit   m_done;
  int   m_done_id;

  int n_vec = 0, n_err = 0;
  int mask_pulses;
  bit rec_done, rec_set;
  int done_seen[$];
  int set_seen[$];

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: observed %0h expected %0h (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  task automatic idle_inputs();
    meta_valid_i = 0; meta_req_id_i = '0; meta_vm_i = 0; meta_cnt_i = '0;
    meta_set_i = '0; meta_off_i = '0; seq_valid_i = 0; mask_valid_i = 0;
    lane_ready_i = '0;
  endtask

  // seq_valid_i may only be raised while a request is queued.
  task automatic seq_drive(input bit want);
    seq_valid_i = want && (mq.size() != 0);
  endtask

  task automatic put_meta(input int id, input bit vm, input int cnt, input int set,
                          input int off);
    meta_valid_i = 1; meta_req_id_i = ReqIdW'(id); meta_vm_i = vm;
    meta_cnt_i = CntW'(cnt); meta_set_i = SetW'(set); meta_off_i = OffW'(off);
  endtask

  // Called at a negedge with inputs driven: checks outputs, advances model at posedge.
  task automatic tick();
    bit empty, full, e_sready, e_cmt, lastb;
    req_t h;
    logic [NrLanes-1:0] acked;
    #1;
    empty = (mq.size() == 0);
    full  = (mq.size() == InfoDepth);
    h = '{default: 0};
    if (!empty) h = mq[0];
    e_sready = (m_pend == '0) && !empty && (h.vm || mask_valid_i);
    e_cmt    = seq_valid_i && e_sready;
    check_eq("meta_ready", 32'(meta_ready_o), 32'(!full));
    check_eq("seq_ready", 32'(seq_ready_o), 32'(e_sready));
    check_eq("cmt", 32'(cmt_o), 32'(e_cmt));
    check_eq("mask_ready", 32'(mask_ready_o), 32'(e_cmt && !h.vm));
    check_eq("lane_valid", 32'(lane_valid_o), 32'(m_pend));
    check_eq("done_valid", 32'(done_valid_o), 32'(m_done));
    check_eq("busy", 32'(busy_o), 32'(!empty || (m_pend != '0) || m_done));
    if (m_done) check_eq("done_req_id", 32'(done_req_id_o), 32'(m_done_id));
    if (!empty) begin
      check_eq("cur_req_id", 32'(cur_req_id_o), 32'(h.id));
      check_eq("cur_vm", 32'(cur_vm_o), 32'(h.vm));
      check_eq("cur_set", 32'(cur_set_o), 32'((h.set + m_beat) % (1 << SetW)));
      check_eq("cur_off", 32'(cur_off_o), 32'(h.off));
    end
    if (mask_ready_o) mask_pulses++;
    if (rec_done && done_valid_o) done_seen.push_back(int'(done_req_id_o));
    if (rec_set && cmt_o) set_seen.push_back(int'(cur_set_o));
    @(posedge clk_i);
    acked  = m_pend & ~lane_ready_i;
    m_done = (m_pend != '0) && (acked == '0) && m_last;
    if (m_done) begin
      m_done_id = m_pend_id;
      m_last    = 0;
    end
    m_pend = acked;
    if (e_cmt) begin
      lastb     = (m_beat == h.cnt);
      m_pend    = '1;
      m_last    = lastb;
      m_pend_id = h.id;
      if (lastb) begin
        void'(mq.pop_front());
        m_beat = 0;
      end else begin
        m_beat++;
      end
    end
    if (meta_valid_i && !full)
      mq.push_back('{id: int'(meta_req_id_i), vm: meta_vm_i, cnt: int'(meta_cnt_i),
                     set: int'(meta_set_i), off: int'(meta_off_i)});
    @(negedge clk_i);
  endtask

  task automatic do_reset();
    rst_i = 1;
    idle_inputs();
    @(posedge clk_i);
    mq.delete();
    m_beat = 0; m_pend = '0; m_last = 0; m_pend_id = 0; m_done = 0; m_done_id = 0;
    @(negedge clk_i);
    rst_i = 0;
    #1;
    check_eq("rst_cur_set", 32'(cur_set_o), 32'd0);
    check_eq("rst_cur_req_id", 32'(cur_req_id_o), 32'd0);
  endtask

  initial begin
    idle_inputs();
    mask_pulses = 0; rec_done = 0; rec_set = 0;
    do_reset();
    tick();

    // Single unmasked 3-beat request with immediate lane acks.
    rec_set = 1;
    put_meta(3, 1, 2, 10, 5);
    tick();
    meta_valid_i = 0;
    mask_pulses = 0;
    rec_done = 1;
    for (int i = 0; i < 10; i++) begin
      lane_ready_i = '1;
      seq_drive(1);
      tick();
    end
    check_eq("t1_cmt_sets_n", 32'(set_seen.size()), 32'd3);
    if (set_seen.size() == 3) begin
      check_eq("t1_set0", 32'(set_seen[0]), 32'd10);
      check_eq("t1_set2", 32'(set_seen[2]), 32'd12);
    end
    check_eq("t1_ndone", 32'(done_seen.size()), 32'd1);
    if (done_seen.size() == 1) check_eq("t1_done_id", 32'(done_seen[0]), 32'd3);
    check_eq("t1_mask_pulses", 32'(mask_pulses), 32'd0);
    rec_set = 0; rec_done = 0;

    // Masked request stalls until mask bits arrive.
    do_reset();
    put_meta(7, 0, 1, 100, 2);
    tick();
    meta_valid_i = 0;
    mask_pulses = 0;
    for (int i = 0; i < 11; i++) begin
      mask_valid_i = (i >= 5);
      lane_ready_i = '1;
      seq_drive(1);
      tick();
    end
    check_eq("t2_mask_pulses", 32'(mask_pulses), 32'd2);

    // Staggered lane drain blocks the next beat.
    do_reset();
    put_meta(5, 1, 1, 20, 0);
    tick();
    meta_valid_i = 0;
    seq_drive(1);
    tick();
    foreach (lane_ready_i[l]) lane_ready_i[l] = 1'b0;
    for (int i = 0; i < 4; i++) begin
      case (i)
        0: lane_ready_i = 4'b0001;
        1: lane_ready_i = 4'b0100;
        2: lane_ready_i = 4'b0010;
        default: lane_ready_i = 4'b1000;
      endcase
      seq_drive(1);
      tick();
    end
    for (int i = 0; i < 4; i++) begin
      lane_ready_i = '1;
      seq_drive(1);
      tick();
    end

    // Queue fill and wrap, done ids in order.
    do_reset();
    for (int i = 0; i < 5; i++) begin
      put_meta(i, 1, 0, i, 0);
      tick();
    end
    put_meta(4, 1, 0, 4, 0);
    seq_drive(1);
    tick();
    seq_valid_i = 0;
    tick();
    meta_valid_i = 0;
    done_seen.delete();
    rec_done = 1;
    for (int i = 0; i < 20; i++) begin
      lane_ready_i = '1;
      seq_drive(1);
      tick();
    end
    rec_done = 0;
    check_eq("t4_ndone", 32'(done_seen.size()), 32'd5);
    foreach (done_seen[i]) check_eq("t4_done_order", 32'(done_seen[i]), 32'(i));

    // Set address wraps modulo 2^SetW.
    do_reset();
    set_seen.delete();
    rec_set = 1;
    put_meta(9, 1, 1, 1023, 1);
    tick();
    meta_valid_i = 0;
    for (int i = 0; i < 6; i++) begin
      lane_ready_i = '1;
      seq_drive(1);
      tick();
    end
    rec_set = 0;
    check_eq("t5_nsets", 32'(set_seen.size()), 32'd2);
    if (set_seen.size() == 2) begin
      check_eq("t5_set0", 32'(set_seen[0]), 32'd1023);
      check_eq("t5_set1", 32'(set_seen[1]), 32'd0);
    end

    // Reset in the middle of a request discards everything.
    do_reset();
    put_meta(6, 1, 2, 40, 3);
    tick();
    meta_valid_i = 0;
    seq_drive(1);
    tick();
    seq_valid_i = 0;
    check_eq("t6_pend_full", 32'(lane_valid_o), 32'hf);
    do_reset();
    for (int i = 0; i < 4; i++) begin
      lane_ready_i = '1;
      tick();
    end

    // Randomized traffic.
    do_reset();
    for (int c = 0; c < 3000; c++) begin
      if ($urandom_range(499) == 0) do_reset();
      meta_valid_i  = $urandom_range(1);
      meta_req_id_i = ReqIdW'($urandom);
      meta_vm_i     = $urandom_range(1);
      meta_cnt_i    = CntW'($urandom_range(3));
      meta_set_i    = SetW'($urandom);
      meta_off_i    = OffW'($urandom);
      mask_valid_i  = $urandom_range(1);
      lane_ready_i  = NrLanes'($urandom);
      seq_drive($urandom_range(3) != 0);
      tick();
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
